// File: rtl/fir_pkg.sv
// Shared constants for the FIR output path: sample width and the default
// warm-up length derived from the filter order.
package fir_pkg;
  localparam int FIR_TAPS = 123;
  localparam int DW_DEF   = 16;

  // A FIR of N taps needs N-1 samples before its output is free of the
  // zero-initialised delay line.
  function automatic int skip_for(input int taps);
    return (taps > 0) ? taps - 1 : 0;
  endfunction

  localparam int SKIP_DEF = skip_for(FIR_TAPS);
endpackage

// File: rtl/fir_decim_fifo_sync_fifo.sv
// Show-ahead register-array FIFO: head is visible on dout while non-empty;
// a pop makes room for a same-cycle push even when full.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Masked while empty so the output reads zero out of reset.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fir_decim_fifo.sv
// FIR output stage: drops the start-up transient, decimates by DECIM and
// buffers kept samples for a valid/ready consumer, flagging any drop.
module fir_decim_fifo
  import fir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DECIM = 4,
  parameter int SKIP  = SKIP_DEF,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [DW-1:0]          s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DW-1:0]          m_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf
);
  localparam int SCW = (SKIP > 0)  ? $clog2(SKIP + 1) : 1;
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM)    : 1;

  logic [SCW-1:0] skip_cnt;
  logic [PW-1:0]  phase;
  logic           warm, keep, empty, full, drop;

  assign warm = (skip_cnt == SCW'(SKIP));
  assign keep = s_valid & warm & (phase == '0);
  // A pop on the same edge frees the slot, so only a stalled full FIFO drops.
  assign drop = keep & full & ~m_ready;
  assign m_valid = ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt <= '0;
      phase    <= '0;
    end else if (s_valid) begin
      if (!warm)
        skip_cnt <= skip_cnt + 1'b1;
      else if (phase == PW'(DECIM - 1))
        phase <= '0;
      else
        phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .pop   (m_ready),
    .din   (s_data),
    .dout  (m_data),
    .empty (empty),
    .full  (full),
    .level (level)
  );
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: two instances (DECIM=1/SKIP=0 and DECIM=4/SKIP=3)
// share stimulus; a queue-based reference model predicts each one.
module tb_fir_decim_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, s_valid, m_ready, clr_ovf;
  logic [DW-1:0] s_data;
  logic [1:0]    m_valid, overflow;
  logic [DW-1:0] m_data [2];
  logic [LW-1:0] level  [2];

  always #5 clk = ~clk;

  fir_decim_fifo #(.DW(DW), .DECIM(1), .SKIP(0), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
    .level(level[0]), .overflow(overflow[0]), .clr_ovf(clr_ovf));

  fir_decim_fifo #(.DW(DW), .DECIM(4), .SKIP(3), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
    .level(level[1]), .overflow(overflow[1]), .clr_ovf(clr_ovf));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int decim_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction
  function automatic int skip_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Reference model: sample counters plus a plain queue of buffered samples.
  logic [DW-1:0] sbq [2][$];
  int            seen [2];
  logic          ovf_m [2];
  logic [DW-1:0] out_b [$];
  bit            rec_b = 1'b0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      seen[k]  = 0;
      ovf_m[k] = 1'b0;
    end
  end

  // Outputs are compared mid-cycle; the inputs then visible are the ones the
  // next rising edge will consume, so the model is advanced with them here.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int  sz, post;
      bit  pop_ok, keep, dropped;
      sz = sbq[k].size();
      chk($sformatf("level[%0d]", k), 32'(level[k]), 32'(sz));
      chk($sformatf("m_valid[%0d]", k), 32'(m_valid[k]), 32'(sz > 0));
      chk($sformatf("overflow[%0d]", k), 32'(overflow[k]), 32'(ovf_m[k]));
      if (sz > 0) chk($sformatf("m_data[%0d]", k), 32'(m_data[k]), 32'(sbq[k][0]));
      if (rst) begin
        sbq[k].delete();
        seen[k]  = 0;
        ovf_m[k] = 1'b0;
      end else begin
        pop_ok = m_ready && (sz > 0);
        if (pop_ok) begin
          if (k == 1 && rec_b) out_b.push_back(sbq[k][0]);
          void'(sbq[k].pop_front());
        end
        keep = 1'b0;
        if (s_valid) begin
          post = seen[k] - skip_of(k);
          keep = (post >= 0) && (post % decim_of(k) == 0);
          seen[k]++;
        end
        dropped = 1'b0;
        if (keep) begin
          if (sz < DEPTH || pop_ok) sbq[k].push_back(s_data);
          else dropped = 1'b1;
        end
        if (dropped)      ovf_m[k] = 1'b1;
        else if (clr_ovf) ovf_m[k] = 1'b0;
      end
    end
  end

  task automatic step(input logic r, input logic sv, input logic [DW-1:0] d,
                      input logic rdy, input logic clr);
    rst = r; s_valid = sv; s_data = d; m_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and pass-through with no decimation on instance A.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset m_data a", 32'(m_data[0]), 0);
    chk("reset m_data b", 32'(m_data[1]), 0);
    step(0, 1, 16'd1, 1, 0);
    step(0, 1, 16'd2, 1, 0);
    step(0, 1, 16'd3, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

    // Warm-up then decimation on instance B: 0..15 -> 3,7,11,15.
    step(1, 0, 0, 1, 0);
    rec_b = 1'b1;
    for (int i = 0; i < 16; i++) step(0, 1, 16'(i), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    rec_b = 1'b0;
    chk("decim count", 32'(out_b.size()), 4);
    if (out_b.size() == 4) begin
      chk("decim out0", 32'(out_b[0]), 3);
      chk("decim out1", 32'(out_b[1]), 7);
      chk("decim out2", 32'(out_b[2]), 11);
      chk("decim out3", 32'(out_b[3]), 15);
    end

    // Fill past DEPTH with consumer stalled.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 83; i++) step(0, 1, 16'(i), 0, 0);
    chk("full level", 32'(level[1]), 16);
    chk("full m_valid", 32'(m_valid[1]), 1);
    chk("full overflow", 32'(overflow[1]), 1);
    chk("full head", 32'(m_data[1]), 3);

    // clr_ovf alone clears; push+pop while full keeps level and no overflow.
    step(0, 0, 0, 0, 1);
    chk("clr ovf", 32'(overflow[1]), 0);
    step(0, 1, 16'd1000, 1, 0);
    chk("push+pop full level", 32'(level[1]), 16);
    chk("push+pop full ovf", 32'(overflow[1]), 0);
    chk("push+pop new head", 32'(m_data[1]), 7);

    // Drop coincident with clr_ovf: set wins.
    for (int i = 0; i < 4; i++) step(0, 1, 16'(2000 + i), 0, 1);
    chk("clr vs drop", 32'(overflow[1]), 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
    chk("drained", 32'(level[1]), 0);

    // Mid-stream reset with 5 buffered samples.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) step(0, 1, 16'(500 + i), 0, 0);
    chk("hold five", 32'(level[1]), 5);
    step(1, 0, 0, 0, 0);
    chk("rst m_valid", 32'(m_valid[1]), 0);
    chk("rst level", 32'(level[1]), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'(900 + i), 1, 0);
    step(0, 0, 0, 1, 0);
    chk("rewarm no output", 32'(level[1]), 0);
    chk("rewarm m_valid", 32'(m_valid[1]), 0);

    // Randomised traffic with bursty consumer and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom), rdy, ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
